// File: rtl/interrupt_pkg.sv
// Shared definitions for the interrupt controller: sizes, register map and FSM states.
package interrupt_pkg;

  localparam int NUM_IRQ         = 16;
  localparam int BLACKOUT_CYCLES = 3;
  localparam int CNT_W           = 2;

  localparam logic [1:0] SEL_MASK    = 2'd0;
  localparam logic [1:0] SEL_EDGE    = 2'd1;
  localparam logic [1:0] SEL_PENDING = 2'd2;
  localparam logic [1:0] SEL_CTRL    = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    FIRE,
    BLACKOUT
  } state_t;

endpackage

// File: rtl/interrupt_controller_if.sv
// CPU-side bundle of the interrupt controller: requests, pipeline status, config bus, vector outputs.
interface interrupt_controller_if;
  import interrupt_pkg::*;

  logic [NUM_IRQ-1:0] irq;
  logic               hazard;
  logic               branch_hazard;
  logic               p_cache_miss;
  logic               flow_change;
  logic               int_ret;
  logic               cfg_we;
  logic [1:0]         cfg_sel;
  logic [NUM_IRQ-1:0] cfg_wdata;
  logic [NUM_IRQ-1:0] cfg_rdata;
  logic               interrupt;
  logic [3:0]         int_addr;
  logic [NUM_IRQ-1:0] isr_active;

  modport slave (
    input  irq, hazard, branch_hazard, p_cache_miss, flow_change, int_ret,
    input  cfg_we, cfg_sel, cfg_wdata,
    output cfg_rdata, interrupt, int_addr, isr_active
  );

  modport master (
    output irq, hazard, branch_hazard, p_cache_miss, flow_change, int_ret,
    output cfg_we, cfg_sel, cfg_wdata,
    input  cfg_rdata, interrupt, int_addr, isr_active
  );

endinterface

// File: rtl/irq_sync.sv
// Two-flop synchronizer for the asynchronous irq lines plus a rising-edge detector on the clean copy.
module irq_sync import interrupt_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [NUM_IRQ-1:0] s_irq,
  output logic [NUM_IRQ-1:0] rise
);

  logic [NUM_IRQ-1:0] meta;
  logic [NUM_IRQ-1:0] s_prev;

  // Metastability flop, synchronized value, and a delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= '0;
      s_irq  <= '0;
      s_prev <= '0;
    end else begin
      meta   <= irq;
      s_irq  <= meta;
      s_prev <= s_irq;
    end
  end

  assign rise = s_irq & ~s_prev;

endmodule

// File: rtl/interrupt_controller.sv
// Prioritised, nestable interrupt controller that vectors the PC only when the pipeline is quiet.
module interrupt_controller (
  input  logic clk,
  input  logic rst,
  interrupt_controller_if.slave bus
);
  import interrupt_pkg::*;

  logic [NUM_IRQ-1:0] s_irq;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] edge_sel;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] pending_next;
  logic [NUM_IRQ-1:0] isr_active;
  logic [NUM_IRQ-1:0] isr_next;
  logic [NUM_IRQ-1:0] candidate;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] addr_onehot;
  logic               gie;
  logic [4:0]         winner;
  logic [4:0]         cur_prio;
  logic               stall;
  logic               fire_ok;
  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic [3:0]         int_addr;
  logic [3:0]         addr_next;

  irq_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .irq   (bus.irq),
    .s_irq (s_irq),
    .rise  (rise)
  );

  assign candidate   = pending & mask;
  assign addr_onehot = NUM_IRQ'(1) << int_addr;
  assign w1c         = (bus.cfg_we && bus.cfg_sel == SEL_PENDING) ? bus.cfg_wdata : '0;
  assign stall       = bus.hazard | bus.branch_hazard | bus.p_cache_miss |
                       bus.flow_change | bus.int_ret;
  // A winner of 16 means "none"; it can never be below cur_prio, which tops out at 16.
  assign fire_ok     = gie && (winner < cur_prio) && !stall;

  // Winner: lowest-numbered requesting line that is also unmasked.
  always_comb begin
    winner = 5'd16;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (candidate[i]) winner = 5'(i);
    end
  end

  // Current priority: lowest in-service line, or 16 when nothing is being serviced.
  always_comb begin
    cur_prio = 5'd16;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (isr_active[i]) cur_prio = 5'(i);
    end
  end

  // Configuration registers written from the CPU bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask     <= '0;
      edge_sel <= '0;
      gie      <= 1'b0;
    end else if (bus.cfg_we) begin
      case (bus.cfg_sel)
        SEL_MASK: mask     <= bus.cfg_wdata;
        SEL_EDGE: edge_sel <= bus.cfg_wdata;
        SEL_CTRL: gie      <= bus.cfg_wdata[0];
        default:  ;
      endcase
    end
  end

  // Combinational register readback.
  always_comb begin
    bus.cfg_rdata = '0;
    case (bus.cfg_sel)
      SEL_MASK:    bus.cfg_rdata = mask;
      SEL_EDGE:    bus.cfg_rdata = edge_sel;
      SEL_PENDING: bus.cfg_rdata = pending;
      SEL_CTRL:    bus.cfg_rdata = {{(NUM_IRQ-1){1'b0}}, gie};
      default:     bus.cfg_rdata = '0;
    endcase
  end

  // Edge lines latch rises (a rise beats any clear); level lines just follow the input.
  // In-service: int_ret retires the lowest bit, and leaving FIRE marks the fired line.
  always_comb begin
    pending_next = (edge_sel & ((pending & ~(w1c | ((state == FIRE) ? addr_onehot : '0))) | rise))
                 | (~edge_sel & s_irq);
    isr_next = isr_active;
    if (bus.int_ret) isr_next = isr_active & (isr_active - NUM_IRQ'(1));
    if (state == FIRE) isr_next = isr_next | addr_onehot;
  end

  // Pending and in-service bitmaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      isr_active <= '0;
    end else begin
      pending    <= pending_next;
      isr_active <= isr_next;
    end
  end

  // Vectoring FSM: one-cycle FIRE, then a fixed blackout that may chain straight into the next FIRE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    addr_next  = int_addr;
    case (state)
      IDLE: begin
        if (fire_ok) begin
          state_next = FIRE;
          addr_next  = winner[3:0];
        end
      end
      FIRE: begin
        state_next = BLACKOUT;
        cnt_next   = CNT_W'(BLACKOUT_CYCLES - 1);
      end
      BLACKOUT: begin
        if (cnt == '0) begin
          if (fire_ok) begin
            state_next = FIRE;
            addr_next  = winner[3:0];
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, blackout counter and latched vector index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      int_addr <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      int_addr <= addr_next;
    end
  end

  assign bus.interrupt  = (state == FIRE);
  assign bus.int_addr   = int_addr;
  assign bus.isr_active = isr_active;

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench: expected vector indices are queued as requests are driven and checked on each pulse.
module tb_interrupt_controller;
  import interrupt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  interrupt_controller_if bus();

  interrupt_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors       = 0;
  int miscompares   = 0;
  int cyc           = 0;
  int fire_count    = 0;
  int last_fire_cyc = 0;
  int prev_fire_cyc = 0;
  logic [3:0] exp_q[$];

  // Free-running edge counter for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every interrupt pulse consumes one scoreboard entry; a pulse with nothing queued is spurious.
  always @(negedge clk) begin
    if (bus.interrupt === 1'b1) begin
      prev_fire_cyc = last_fire_cyc;
      last_fire_cyc = cyc;
      fire_count++;
      if (exp_q.size() == 0) checkOutput("spurious_interrupt", 32'd1, 32'd0);
      else checkOutput("int_addr", 32'(bus.int_addr), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfgWrite(input logic [1:0] sel, input logic [15:0] data);
    bus.cfg_we    = 1'b1;
    bus.cfg_sel   = sel;
    bus.cfg_wdata = data;
    tick(1);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic readCfg(input logic [1:0] sel, output logic [15:0] d);
    bus.cfg_sel = sel;
    #1;
    d = bus.cfg_rdata;
  endtask

  task automatic applyStimulus(input logic [15:0] bits);
    bus.irq = bits;
    tick(1);
    bus.irq = '0;
  endtask

  task automatic pulseRet();
    bus.int_ret = 1'b1;
    tick(1);
    bus.int_ret = 1'b0;
  endtask

  task automatic setStall(input int k, input logic v);
    case (k)
      0: bus.hazard        = v;
      1: bus.branch_hazard = v;
      2: bus.p_cache_miss  = v;
      default: bus.flow_change = v;
    endcase
  endtask

  // Bounded wait for the monitor to see the target number of pulses; ends one edge later.
  task automatic waitFires(input int target, input int budget, input string tag);
    int n = 0;
    while (fire_count < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput(tag, 32'(fire_count), 32'(target));
    @(posedge clk);
    #1;
  endtask

  task automatic holdNoFire(input int n, input string tag);
    int fc0 = fire_count;
    tick(n);
    checkOutput(tag, 32'(fire_count), 32'(fc0));
  endtask

  initial begin
    logic [15:0] rd;
    int start;

    bus.irq = '0; bus.hazard = 0; bus.branch_hazard = 0; bus.p_cache_miss = 0;
    bus.flow_change = 0; bus.int_ret = 0; bus.cfg_we = 0; bus.cfg_sel = '0; bus.cfg_wdata = '0;

    $display("[TB] reset state");
    tick(2);
    checkOutput("rst_interrupt", 32'(bus.interrupt), 0);
    checkOutput("rst_int_addr", 32'(bus.int_addr), 0);
    checkOutput("rst_isr", 32'(bus.isr_active), 0);
    for (int s = 0; s < 4; s++) begin
      readCfg(2'(s), rd);
      checkOutput($sformatf("rst_cfg%0d", s), 32'(rd), 0);
    end
    rst = 1'b0;
    tick(1);

    $display("[TB] single edge");
    cfgWrite(SEL_MASK, 16'h0010);
    cfgWrite(SEL_EDGE, 16'h0010);
    cfgWrite(SEL_CTRL, 16'h0001);
    start = cyc;
    exp_q.push_back(4'd4);
    applyStimulus(16'h0010);
    waitFires(fire_count + 1, 20, "t1_timeout");
    checkOutput("t1_latency", 32'(last_fire_cyc - start), 4);
    readCfg(SEL_PENDING, rd);
    checkOutput("t1_pending", 32'(rd), 0);
    checkOutput("t1_isr", 32'(bus.isr_active), 32'h0010);
    pulseRet();
    checkOutput("t1_isr_ret", 32'(bus.isr_active), 0);

    $display("[TB] priority");
    cfgWrite(SEL_MASK, 16'h0204);
    cfgWrite(SEL_EDGE, 16'h0204);
    exp_q.push_back(4'd2);
    applyStimulus(16'h0204);
    waitFires(fire_count + 1, 20, "t2_timeout_a");
    checkOutput("t2_isr_a", 32'(bus.isr_active), 32'h0004);
    readCfg(SEL_PENDING, rd);
    checkOutput("t2_pending", 32'(rd), 32'h0200);
    holdNoFire(10, "t2_hold");
    exp_q.push_back(4'd9);
    pulseRet();
    waitFires(fire_count + 1, 20, "t2_timeout_b");
    checkOutput("t2_isr_b", 32'(bus.isr_active), 32'h0200);
    pulseRet();

    $display("[TB] nesting");
    cfgWrite(SEL_MASK, 16'h00A8);
    cfgWrite(SEL_EDGE, 16'h00A8);
    exp_q.push_back(4'd5);
    applyStimulus(16'h0020);
    waitFires(fire_count + 1, 20, "t3_timeout_5");
    checkOutput("t3_isr_5", 32'(bus.isr_active), 32'h0020);
    exp_q.push_back(4'd3);
    applyStimulus(16'h0008);
    waitFires(fire_count + 1, 20, "t3_timeout_3");
    checkOutput("t3_isr_3", 32'(bus.isr_active), 32'h0028);
    tick(4);
    applyStimulus(16'h0080);
    holdNoFire(10, "t3_hold_a");
    readCfg(SEL_PENDING, rd);
    checkOutput("t3_pending7", 32'(rd), 32'h0080);
    pulseRet();
    checkOutput("t3_isr_ret1", 32'(bus.isr_active), 32'h0020);
    holdNoFire(8, "t3_hold_b");
    exp_q.push_back(4'd7);
    pulseRet();
    waitFires(fire_count + 1, 20, "t3_timeout_7");
    checkOutput("t3_isr_7", 32'(bus.isr_active), 32'h0080);
    pulseRet();

    $display("[TB] stall gating");
    cfgWrite(SEL_MASK, 16'h0002);
    cfgWrite(SEL_EDGE, 16'h0002);
    for (int k = 0; k < 4; k++) begin
      setStall(k, 1'b1);
      exp_q.push_back(4'd1);
      applyStimulus(16'h0002);
      holdNoFire(8, $sformatf("t4_stalled%0d", k));
      start = cyc;
      setStall(k, 1'b0);
      waitFires(fire_count + 1, 10, $sformatf("t4_timeout%0d", k));
      checkOutput($sformatf("t4_latency%0d", k), 32'(last_fire_cyc - start), 1);
      pulseRet();
      tick(2);
    end

    $display("[TB] blackout spacing");
    cfgWrite(SEL_MASK, 16'h0003);
    cfgWrite(SEL_EDGE, 16'h0003);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd0);
    applyStimulus(16'h0002);
    applyStimulus(16'h0001);
    waitFires(fire_count + 2, 30, "t5_timeout");
    checkOutput("t5_spacing", 32'(last_fire_cyc - prev_fire_cyc), 4);
    checkOutput("t5_isr", 32'(bus.isr_active), 32'h0003);
    pulseRet();
    pulseRet();
    checkOutput("t5_isr_clear", 32'(bus.isr_active), 0);

    $display("[TB] reset during blackout");
    cfgWrite(SEL_MASK, 16'h0040);
    cfgWrite(SEL_EDGE, 16'h0040);
    exp_q.push_back(4'd6);
    applyStimulus(16'h0040);
    waitFires(fire_count + 1, 20, "t6_timeout");
    rst = 1'b1;
    #1;
    checkOutput("t6_interrupt", 32'(bus.interrupt), 0);
    checkOutput("t6_int_addr", 32'(bus.int_addr), 0);
    checkOutput("t6_isr", 32'(bus.isr_active), 0);
    readCfg(SEL_MASK, rd);
    checkOutput("t6_mask", 32'(rd), 0);
    readCfg(SEL_CTRL, rd);
    checkOutput("t6_gie", 32'(rd), 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    cfgWrite(SEL_MASK, 16'hFFFF);
    bus.irq = 16'hFFFF;
    holdNoFire(12, "t6_gie_off");
    readCfg(SEL_PENDING, rd);
    checkOutput("t6_level_pending", 32'(rd), 32'hFFFF);
    cfgWrite(SEL_PENDING, 16'hFFFF);
    readCfg(SEL_PENDING, rd);
    checkOutput("t6_level_w1c", 32'(rd), 32'hFFFF);
    bus.irq = '0;
    tick(4);
    readCfg(SEL_PENDING, rd);
    checkOutput("t6_level_drop", 32'(rd), 0);
    checkOutput("queue_empty", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
